// File: rtl/vout_ir.sv
// NEC infrared transmitter output plugin.
// Sends a full NEC frame (9 ms leader, 4.5 ms space, 32 data bits, stop burst) or a
// repeat frame (9 ms leader, 2.25 ms space, stop burst), then holds busy for a gap.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   send         - start request, only looked at while busy is low
//   repeat_frame - sampled with send; 1 selects a repeat frame
//   address      - NEC address, latched on accept
//   command      - NEC command, latched on accept
//   ir_out       - registered LED drive (carrier-modulated or plain envelope, optional invert)
//   busy         - high from accept through the end of the post-frame gap
//   done         - one-cycle pulse on the last cycle of the stop burst
module vout_ir #(
  parameter int unsigned TICK_DIV     = 50,
  parameter bit          CARRIER_EN   = 1'b1,
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned GAP_US       = 40000,
  parameter bit          INVERT       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic       repeat_frame,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       ir_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MaxDur = (GAP_US > 9000) ? GAP_US : 9000;
  localparam int unsigned DurW   = $clog2(MaxDur + 1);
  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CarW   = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLeadM,
    StLeadS,
    StBitM,
    StBitS,
    StStopM,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [DurW-1:0]   dur_q, dur_d, dur_last;
  logic [31:0]       shift_q, shift_d;
  logic [5:0]        bit_q, bit_d;
  logic              rep_q, rep_d;
  logic [CarW-1:0]   car_cnt_q, car_cnt_d;
  logic              car_ph_q, car_ph_d;
  logic              ir_q, ir_d;
  logic              tick, seg_end, accept, mark_d, env_d;

  // Last tick index of the current state; every state lasts dur_last+1 ticks.
  always_comb begin
    dur_last = '0;
    unique case (state_q)
      StLeadM: dur_last = DurW'(9000 - 1);
      StLeadS: dur_last = rep_q ? DurW'(2250 - 1) : DurW'(4500 - 1);
      StBitM:  dur_last = DurW'(560 - 1);
      StBitS:  dur_last = shift_q[0] ? DurW'(1690 - 1) : DurW'(560 - 1);
      StStopM: dur_last = DurW'(560 - 1);
      StGap:   dur_last = DurW'(GAP_US - 1);
      default: dur_last = '0;
    endcase
  end

  assign tick    = (pre_q == PreW'(TICK_DIV - 1));
  assign seg_end = (state_q != StIdle) && tick && (dur_q == dur_last);
  assign accept  = (state_q == StIdle) && send;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    if (accept) begin
      state_d = StLeadM;
      shift_d = {~command, command, ~address, address};
      bit_d   = '0;
      rep_d   = repeat_frame;
    end else if (seg_end) begin
      unique case (state_q)
        StLeadM: state_d = StLeadS;
        StLeadS: state_d = rep_q ? StStopM : StBitM;
        StBitM:  state_d = StBitS;
        StBitS: begin
          if (bit_q == 6'd31) begin
            state_d = StStopM;
          end else begin
            state_d = StBitM;
            shift_d = {1'b0, shift_q[31:1]};
            bit_d   = bit_q + 6'd1;
          end
        end
        StStopM: state_d = StGap;
        StGap:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler and duration counter restart on accept and on every state change, so each
  // state lasts an exact multiple of TICK_DIV cycles.
  always_comb begin
    pre_d = '0;
    dur_d = '0;
    if (state_q != StIdle && !seg_end) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
      dur_d = tick ? dur_q + DurW'(1) : dur_q;
    end
  end

  // Carrier phase restarts high on the first cycle of each mark. Every mark is entered
  // from a different state, so a state change marks the start.
  always_comb begin
    mark_d    = (state_d == StLeadM) || (state_d == StBitM) || (state_d == StStopM);
    car_cnt_d = '0;
    car_ph_d  = 1'b1;
    if (mark_d && state_d == state_q) begin
      if (car_cnt_q == CarW'(CARRIER_HALF - 1)) begin
        car_ph_d = ~car_ph_q;
      end else begin
        car_cnt_d = car_cnt_q + CarW'(1);
        car_ph_d  = car_ph_q;
      end
    end
    env_d = mark_d & (CARRIER_EN ? car_ph_d : 1'b1);
    ir_d  = env_d ^ INVERT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      dur_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      rep_q     <= 1'b0;
      car_cnt_q <= '0;
      car_ph_q  <= 1'b0;
      ir_q      <= INVERT;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      dur_q     <= dur_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      rep_q     <= rep_d;
      car_cnt_q <= car_cnt_d;
      car_ph_q  <= car_ph_d;
      ir_q      <= ir_d;
    end
  end

  assign ir_out = ir_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StStopM) && seg_end;

endmodule

// File: tb/tb_vout_ir.sv
// Testbench for vout_ir. Five instances with different parameter sets run in parallel.
// Expected ir_out run-lengths and done cycles are queued when a frame is requested and
// compared as the monitor observes them.
module tb_vout_ir;

  localparam int NI = 5;
  // 0: plain 0x00/0x45 + ignored sends, 1: carrier/invert repeat, 2: 0xA5/0xFF,
  // 3: reset mid-frame, 4: slow tick + carrier repeat
  localparam int unsigned TD_P   [NI] = '{1, 1, 1, 1, 3};
  localparam bit          CE_P   [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam int unsigned HALF_P [NI] = '{658, 4, 658, 658, 7};
  localparam int unsigned GAP_P  [NI] = '{300, 200, 200, 200, 50};
  localparam bit          INV_P  [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct packed {
    logic        lvl;
    logic [31:0] len;
  } seg_t;

  typedef struct {
    int          inst;
    logic [7:0]  a;
    logic [7:0]  c;
    logic        r;
    logic [31:0] word;     // expected transmit order, bit 0 first
    int unsigned done_at;  // busy cycle (1-based) on which done must pulse
    bit          want_done;
  } vec_t;

  logic       clk;
  logic       rst  [NI];
  logic       send [NI];
  logic       rep  [NI];
  logic [7:0] addr [NI];
  logic [7:0] cmd  [NI];
  logic       ir   [NI];
  logic       bsy  [NI];
  logic       dn   [NI];

  seg_t        exp_q [NI][$];
  int unsigned dq    [NI][$];

  bit          run_on  [NI];
  logic        run_lvl [NI];
  int unsigned run_len [NI];
  int unsigned cyc     [NI];

  int nvec  = 0;
  int nfail = 0;

  vec_t tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vout_ir #(.TICK_DIV(TD_P[0]), .CARRIER_EN(CE_P[0]), .CARRIER_HALF(HALF_P[0]),
            .GAP_US(GAP_P[0]), .INVERT(INV_P[0])) u_a (
    .clk(clk), .reset(rst[0]), .send(send[0]), .repeat_frame(rep[0]), .address(addr[0]),
    .command(cmd[0]), .ir_out(ir[0]), .busy(bsy[0]), .done(dn[0]));
  vout_ir #(.TICK_DIV(TD_P[1]), .CARRIER_EN(CE_P[1]), .CARRIER_HALF(HALF_P[1]),
            .GAP_US(GAP_P[1]), .INVERT(INV_P[1])) u_b (
    .clk(clk), .reset(rst[1]), .send(send[1]), .repeat_frame(rep[1]), .address(addr[1]),
    .command(cmd[1]), .ir_out(ir[1]), .busy(bsy[1]), .done(dn[1]));
  vout_ir #(.TICK_DIV(TD_P[2]), .CARRIER_EN(CE_P[2]), .CARRIER_HALF(HALF_P[2]),
            .GAP_US(GAP_P[2]), .INVERT(INV_P[2])) u_c (
    .clk(clk), .reset(rst[2]), .send(send[2]), .repeat_frame(rep[2]), .address(addr[2]),
    .command(cmd[2]), .ir_out(ir[2]), .busy(bsy[2]), .done(dn[2]));
  vout_ir #(.TICK_DIV(TD_P[3]), .CARRIER_EN(CE_P[3]), .CARRIER_HALF(HALF_P[3]),
            .GAP_US(GAP_P[3]), .INVERT(INV_P[3])) u_d (
    .clk(clk), .reset(rst[3]), .send(send[3]), .repeat_frame(rep[3]), .address(addr[3]),
    .command(cmd[3]), .ir_out(ir[3]), .busy(bsy[3]), .done(dn[3]));
  vout_ir #(.TICK_DIV(TD_P[4]), .CARRIER_EN(CE_P[4]), .CARRIER_HALF(HALF_P[4]),
            .GAP_US(GAP_P[4]), .INVERT(INV_P[4])) u_e (
    .clk(clk), .reset(rst[4]), .send(send[4]), .repeat_frame(rep[4]), .address(addr[4]),
    .command(cmd[4]), .ir_out(ir[4]), .busy(bsy[4]), .done(dn[4]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Append a run to the expected waveform, merging with the previous run of the same level.
  task automatic push_seg(input int i, input logic lvl, input int unsigned len);
    seg_t s;
    seg_t t;
    s.lvl = lvl ^ INV_P[i];
    s.len = len;
    if (exp_q[i].size() > 0) begin
      t = exp_q[i].pop_back();
      if (t.lvl == s.lvl) begin
        t.len = t.len + len;
        exp_q[i].push_back(t);
      end else begin
        exp_q[i].push_back(t);
        exp_q[i].push_back(s);
      end
    end else begin
      exp_q[i].push_back(s);
    end
  endtask

  task automatic push_mark(input int i, input int unsigned len);
    int unsigned rem;
    int unsigned n;
    logic        ph;
    if (!CE_P[i]) begin
      push_seg(i, 1'b1, len);
    end else begin
      rem = len;
      ph  = 1'b1;
      while (rem > 0) begin
        n = (rem < HALF_P[i]) ? rem : HALF_P[i];
        push_seg(i, ph, n);
        ph  = ~ph;
        rem = rem - n;
      end
    end
  endtask

  // Queue the expected waveform of one frame (including the gap) and request it.
  task automatic apply(input vec_t v);
    int i;
    int unsigned td;
    i  = v.inst;
    td = TD_P[i];
    push_mark(i, 9000 * td);
    push_seg(i, 1'b0, (v.r ? 2250 : 4500) * td);
    if (!v.r) begin
      for (int b = 0; b < 32; b++) begin
        push_mark(i, 560 * td);
        push_seg(i, 1'b0, (v.word[b] ? 1690 : 560) * td);
      end
    end
    push_mark(i, 560 * td);
    push_seg(i, 1'b0, GAP_P[i] * td);
    if (v.want_done) dq[i].push_back(v.done_at);
    addr[i] = v.a;
    cmd[i]  = v.c;
    rep[i]  = v.r;
    send[i] = 1'b1;
  endtask

  task automatic emit(input int i);
    seg_t s;
    nvec++;
    if (exp_q[i].size() == 0) begin
      nfail++;
      $display("FAIL seg%0d: got unexpected run lvl %0d len %0d, required none", i,
               run_lvl[i], run_len[i]);
    end else begin
      s = exp_q[i].pop_front();
      if (s.lvl !== run_lvl[i] || s.len != run_len[i]) begin
        nfail++;
        $display("FAIL seg%0d: got lvl %0d len %0d, required lvl %0d len %0d", i,
                 run_lvl[i], run_len[i], s.lvl, s.len);
      end
    end
  endtask

  // Run-length monitor: one run per ir_out level while busy; the final run ends with busy.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst[i]) begin
          run_on[i] = 1'b0;
          cyc[i]    = 0;
          exp_q[i].delete();
          dq[i].delete();
        end else begin
          if (bsy[i]) cyc[i] = cyc[i] + 1;
          else cyc[i] = 0;
          if (dn[i]) begin
            nvec++;
            if (dq[i].size() == 0) begin
              nfail++;
              $display("FAIL done%0d: got pulse at busy cycle %0d, required none", i, cyc[i]);
            end else begin
              int unsigned e;
              e = dq[i].pop_front();
              if (cyc[i] != e) begin
                nfail++;
                $display("FAIL done%0d: got busy cycle %0d, required %0d", i, cyc[i], e);
              end
            end
          end
          if (bsy[i]) begin
            if (!run_on[i]) begin
              run_on[i]  = 1'b1;
              run_lvl[i] = ir[i];
              run_len[i] = 1;
            end else if (ir[i] == run_lvl[i]) begin
              run_len[i] = run_len[i] + 1;
            end else begin
              emit(i);
              run_lvl[i] = ir[i];
              run_len[i] = 1;
            end
          end else if (run_on[i]) begin
            emit(i);
            run_on[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int i, input int unsigned budget, input string nm);
    int unsigned n;
    n = 0;
    while (bsy[i] && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(bsy[i]), 32'd0);
  endtask

  task automatic seq_a();
    int unsigned n;
    repeat (9999) step();          // busy cycle 10000, inside the leader space
    send[0] = 1'b1;
    step();
    send[0] = 1'b0;
    n = 0;
    while (!dn[0] && n < 70000) begin
      step();
      n++;
    end
    chk("a_done_seen", 32'(dn[0]), 32'd1);
    repeat (10) step();            // inside the gap
    send[0] = 1'b1;
    step();
    send[0] = 1'b0;
    wait_idle(0, 1000, "a_gap_end");
    send[0] = 1'b1;                // first idle cycle
    step();
    send[0] = 1'b0;
    chk("a_reaccept_busy", 32'(bsy[0]), 32'd1);
    chk("a_reaccept_ir", 32'(ir[0]), 32'd1);
    chk("a_frame_drained", 32'(exp_q[0].size()), 32'd0);
    chk("a_done_drained", 32'(dq[0].size()), 32'd0);
    repeat (20) step();
    chk("a_leader_hold", 32'(ir[0]), 32'd1);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
  endtask

  task automatic seq_d();
    vec_t v;
    int   nd;
    int   nb;
    repeat (42899) step();         // busy cycle 42900: bit 17 mark spans 42711..43270
    chk("d_bit17_mark", 32'(ir[3]), 32'd1);
    chk("d_runs_left", 32'(exp_q[3].size()), 32'd32);
    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
    chk("d_rst_ir", 32'(ir[3]), 32'd0);
    chk("d_rst_busy", 32'(bsy[3]), 32'd0);
    chk("d_rst_done", 32'(dn[3]), 32'd0);
    nd = 0;
    nb = 0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (dn[3]) nd++;
      if (bsy[3]) nb++;
    end
    chk("d_no_done", 32'(nd), 32'd0);
    chk("d_stay_idle", 32'(nb), 32'd0);
    v = '{3, 8'h3C, 8'h12, 1'b0, 32'hED12C33C, 67980, 1'b0};
    apply(v);
    step();
    send[3] = 1'b0;
    repeat (26999) step();         // busy cycle 27000: leader and address byte complete
    chk("d_post_busy", 32'(bsy[3]), 32'd1);
    chk("d_post_runs_left", 32'(exp_q[3].size()), 32'd50);
    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 8'h00, 8'h45, 1'b0, 32'hBA45FF00, 67980, 1'b1};
    tbl[1] = '{1, 8'h12, 8'h34, 1'b1, 32'h0, 11810, 1'b1};
    tbl[2] = '{2, 8'hA5, 8'hFF, 1'b0, 32'h00FF5AA5, 67980, 1'b1};
    tbl[3] = '{3, 8'h00, 8'h45, 1'b0, 32'hBA45FF00, 67980, 1'b0};
    tbl[4] = '{4, 8'h77, 8'h88, 1'b1, 32'h0, 35430, 1'b1};

    for (int i = 0; i < NI; i++) begin
      rst[i]  = 1'b1;
      send[i] = 1'b0;
      rep[i]  = 1'b0;
      addr[i] = 8'h00;
      cmd[i]  = 8'h00;
    end
    repeat (3) step();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ir%0d", i), 32'(ir[i]), 32'(INV_P[i]));
      chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
    end
    step();

    for (int v = 0; v < 5; v++) apply(tbl[v]);
    step();
    for (int i = 0; i < NI; i++) begin
      send[i] = 1'b0;
      addr[i] = 8'($urandom);
      cmd[i]  = 8'($urandom);
      rep[i]  = 1'($urandom);
    end

    fork
      seq_a();
      seq_d();
      wait_idle(1, 13000, "b_idle");
      wait_idle(2, 69000, "c_idle");
      wait_idle(4, 36000, "e_idle");
    join
    step();
    chk("b_runs_drained", 32'(exp_q[1].size()), 32'd0);
    chk("b_done_drained", 32'(dq[1].size()), 32'd0);
    chk("c_runs_drained", 32'(exp_q[2].size()), 32'd0);
    chk("c_done_drained", 32'(dq[2].size()), 32'd0);
    chk("e_runs_drained", 32'(exp_q[4].size()), 32'd0);
    chk("e_done_drained", 32'(dq[4].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
